trap_sequencer: RTL and testbench

Multi-cycle sequencer between the pipeline and the single-ported machine-mode CSR register file. It performs trap entry for synchronous exceptions and interrupts, and trap return for MRET. It does this through a series of single-cycle CSR reads and writes, then issues a PC redirect. While idle it passes the core's Zicsr accesses straight through to the CSR file.

---
 rtl/trap_sequencer_if.sv | 14 +
 rtl/trap_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_trap_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
// CSR access port. The master drives address, enables and write data.
// The slave returns combinational read data.
interface trap_sequencer_if #(
  parameter int AW = 12
);
  logic [AW-1:0] addr;
  logic          ren;
  logic          wen;
  logic [31:0]   wd;
  logic [31:0]   rd;

  modport master (output addr, ren, wen, wd, input rd);
  modport slave  (input addr, ren, wen, wd, output rd);
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer in front of a single-ported CSR file.
// In idle it is a passthrough for the core; otherwise it issues one CSR access per cycle and then redirects fetch.
module trap_sequencer #(
  parameter bit VECTORED_EN = 1'b1,
  parameter int CSR_AW      = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [31:0]      exc_tval,
  input  logic [31:0]      exc_pc,
  input  logic             mret_valid,
  input  logic             irq_valid,
  input  logic [4:0]       irq_code,
  trap_sequencer_if.slave  core_csr,
  trap_sequencer_if.master csr,
  output logic             busy,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             irq_taken,
  output logic             irq_rejected
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD_STATUS = 4'd1;
  localparam logic [3:0] S_RD_MIE    = 4'd2;
  localparam logic [3:0] S_WR_EPC    = 4'd3;
  localparam logic [3:0] S_WR_CAUSE  = 4'd4;
  localparam logic [3:0] S_WR_TVAL   = 4'd5;
  localparam logic [3:0] S_WR_STATUS = 4'd6;
  localparam logic [3:0] S_RD_TVEC   = 4'd7;
  localparam logic [3:0] S_RD_EPC    = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  localparam logic [1:0] K_EXC  = 2'd0;
  localparam logic [1:0] K_IRQ  = 2'd1;
  localparam logic [1:0] K_MRET = 2'd2;

  localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MIE     = CSR_AW'(12'h304);
  localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] A_MTVAL   = CSR_AW'(12'h343);

  logic [3:0]  state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] status_trap;
  logic [31:0] status_mret;
  logic [31:0] tvec_base;
  logic [31:0] tvec_target;
  logic        irq_masked;

  // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M. MRET: MIE<=MPIE, MPIE<=1, MPP<=M.
  assign status_trap = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3],
                        mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
  assign status_mret = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], 1'b1,
                        mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};

  // Only MODE=01 vectors, and only for interrupts; modes 10/11 fall back to direct.
  assign tvec_base   = {csr.rd[31:2], 2'b00};
  assign tvec_target = (VECTORED_EN && (csr.rd[1:0] == 2'b01) && (kind_q == K_IRQ))
                       ? tvec_base + {25'd0, code_q, 2'b00} : tvec_base;
  assign irq_masked  = !mstatus_q[3] || !csr.rd[code_q];

  always_comb begin
    core_csr.rd = csr.rd;
    csr.addr    = core_csr.addr;
    csr.ren     = core_csr.ren;
    csr.wen     = core_csr.wen;
    csr.wd      = core_csr.wd;
    if (state_q != S_IDLE) begin
      core_csr.rd = '0;
      csr.addr    = '0;
      csr.ren     = 1'b0;
      csr.wen     = 1'b0;
      csr.wd      = '0;
    end
    case (state_q)
      S_RD_STATUS: begin csr.addr = A_MSTATUS; csr.ren = 1'b1; end
      S_RD_MIE:    begin csr.addr = A_MIE;     csr.ren = 1'b1; end
      S_WR_EPC:    begin csr.addr = A_MEPC;    csr.wen = 1'b1; csr.wd = {pc_q[31:2], 2'b00}; end
      S_WR_CAUSE:  begin
        csr.addr = A_MCAUSE;
        csr.wen  = 1'b1;
        csr.wd   = {(kind_q == K_IRQ), 26'd0, code_q};
      end
      S_WR_TVAL:   begin csr.addr = A_MTVAL;   csr.wen = 1'b1; csr.wd = tval_q; end
      S_WR_STATUS: begin
        csr.addr = A_MSTATUS;
        csr.wen  = 1'b1;
        csr.wd   = (kind_q == K_MRET) ? status_mret : status_trap;
      end
      S_RD_TVEC:   begin csr.addr = A_MTVEC;   csr.ren = 1'b1; end
      S_RD_EPC:    begin csr.addr = A_MEPC;    csr.ren = 1'b1; end
      default: ;
    endcase
    // A reset landing mid-sequence must not let the pending write through.
    if (reset) csr.wen = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    code_d        = code_q;
    tval_d        = tval_q;
    pc_d          = pc_q;
    mstatus_d     = mstatus_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (exc_valid) begin
          kind_d  = K_EXC;
          code_d  = exc_code;
          tval_d  = exc_tval;
          pc_d    = exc_pc;
          state_d = S_RD_STATUS;
        end else if (mret_valid) begin
          kind_d  = K_MRET;
          state_d = S_RD_STATUS;
        end else if (irq_valid) begin
          kind_d  = K_IRQ;
          code_d  = irq_code;
          tval_d  = '0;
          pc_d    = exc_pc;
          state_d = S_RD_STATUS;
        end
      end
      S_RD_STATUS: begin
        mstatus_d = csr.rd;
        case (kind_q)
          K_MRET:  state_d = S_WR_STATUS;
          K_IRQ:   state_d = S_RD_MIE;
          default: state_d = S_WR_EPC;
        endcase
      end
      S_RD_MIE:    state_d = irq_masked ? S_IDLE : S_WR_EPC;
      S_WR_EPC:    state_d = S_WR_CAUSE;
      S_WR_CAUSE:  state_d = S_WR_TVAL;
      S_WR_TVAL:   state_d = S_WR_STATUS;
      S_WR_STATUS: state_d = (kind_q == K_MRET) ? S_RD_EPC : S_RD_TVEC;
      S_RD_TVEC: begin
        redirect_pc_d = tvec_target;
        state_d       = S_DONE;
      end
      S_RD_EPC: begin
        redirect_pc_d = {csr.rd[31:2], 2'b00};
        state_d       = S_DONE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      kind_q        <= K_EXC;
      code_q        <= '0;
      tval_q        <= '0;
      pc_q          <= '0;
      mstatus_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      code_q        <= code_d;
      tval_q        <= tval_d;
      pc_q          <= pc_d;
      mstatus_q     <= mstatus_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign redirect_valid = (state_q == S_DONE);
  assign irq_taken      = (state_q == S_DONE) && (kind_q == K_IRQ);
  assign irq_rejected   = (state_q == S_RD_MIE) && irq_masked;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a behavioural CSR file plus a rule-level trap model.
// Directed scenarios are followed by randomized trap/interrupt/MRET requests.
module tb_trap_sequencer;
  localparam int EXC  = 0;
  localparam int IRQ  = 1;
  localparam int MRET = 2;
  localparam int ALL  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_tval = '0;
  logic [31:0] exc_pc = '0;
  logic        mret_valid = 1'b0;
  logic        irq_valid = 1'b0;
  logic [4:0]  irq_code = '0;
  logic        busy, redirect_valid, irq_taken, irq_rejected;
  logic [31:0] redirect_pc;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] last_rpc = '0;
  logic [31:0] csr_mem [0:4095];
  int          wr_count = 0;

  trap_sequencer_if #(.AW(12)) core_bus ();
  trap_sequencer_if #(.AW(12)) csr_bus ();

  trap_sequencer #(.VECTORED_EN(1'b1), .CSR_AW(12)) dut (
    .clock          (clock),
    .reset          (reset),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_tval       (exc_tval),
    .exc_pc         (exc_pc),
    .mret_valid     (mret_valid),
    .irq_valid      (irq_valid),
    .irq_code       (irq_code),
    .core_csr       (core_bus),
    .csr            (csr_bus),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq_taken      (irq_taken),
    .irq_rejected   (irq_rejected)
  );

  always #5 clock = ~clock;

  // CSR file: combinational read, write at the clock edge.
  assign csr_bus.rd = csr_mem[csr_bus.addr];
  always @(posedge clock) begin
    if (csr_bus.wen === 1'b1) begin
      csr_mem[csr_bus.addr] <= csr_bus.wd;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] trap_st(input logic [31:0] ms);
    return (ms & ~32'h1888) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] mret_st(input logic [31:0] ms);
    return (ms & ~32'h1888) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0);
  endfunction

  task automatic core_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    core_bus.addr = a; core_bus.wd = d; core_bus.wen = 1'b1;
    @(posedge clock); #1;
    core_bus.wen = 1'b0;
  endtask

  task automatic core_read(input logic [11:0] a, output logic [31:0] d, output logic b);
    @(posedge clock); #1;
    core_bus.addr = a; core_bus.ren = 1'b1;
    @(negedge clock);
    d = core_bus.rd; b = busy;
    @(posedge clock); #1;
    core_bus.ren = 1'b0;
  endtask

  task automatic preset(input logic [31:0] ms, tvec, mie, epc, cause, tval);
    core_write(12'h300, ms);
    core_write(12'h305, tvec);
    core_write(12'h304, mie);
    core_write(12'h341, epc);
    core_write(12'h342, cause);
    core_write(12'h343, tval);
  endtask

  // Rule-level expectation for one request against the given CSR contents.
  task automatic model(input int kind, input logic [31:0] ms, tvec, mie, epc, cause, tval_old,
                       input logic [4:0] code, input logic [31:0] pc, tval,
                       output int n_cyc, output bit redir, output bit taken, output bit rej,
                       output int n_wr, output logic [31:0] e_ms, e_epc, e_cause, e_tval, e_tgt);
    int kk;
    kk = (kind == ALL) ? EXC : kind;
    redir = 0; taken = 0; rej = 0; n_wr = 0; n_cyc = 0;
    e_ms = ms; e_epc = epc; e_cause = cause; e_tval = tval_old; e_tgt = last_rpc;
    if (kk == EXC) begin
      n_cyc = 7; redir = 1; n_wr = 4;
      e_epc = pc & ~32'h3; e_cause = 32'(code); e_tval = tval;
      e_ms = trap_st(ms); e_tgt = tvec & ~32'h3;
    end else if (kk == IRQ) begin
      if (ms[3] && mie[code]) begin
        n_cyc = 8; redir = 1; taken = 1; n_wr = 4;
        e_epc = pc & ~32'h3; e_cause = 32'h8000_0000 | 32'(code); e_tval = 32'h0;
        e_ms = trap_st(ms);
        e_tgt = (tvec & ~32'h3) + ((tvec[1:0] == 2'b01) ? 32'(code) * 32'd4 : 32'd0);
      end else begin
        n_cyc = 2; rej = 1;
      end
    end else begin
      n_cyc = 4; redir = 1; n_wr = 1;
      e_ms = mret_st(ms); e_tgt = epc & ~32'h3;
    end
  endtask

  // Issues one request and records per-cycle output activity from T (bit 0) to T+11.
  task automatic run_req(input int kind, input logic [4:0] code, input logic [31:0] pc, tval,
                         input bit noise, output logic [15:0] busy_m, redir_m, taken_m, rej_m,
                         output logic [31:0] rpc, output int nwr);
    int w0;
    busy_m = '0; redir_m = '0; taken_m = '0; rej_m = '0; rpc = '0;
    @(posedge clock); #1;
    w0 = wr_count;
    exc_code = code; exc_pc = pc; exc_tval = tval; irq_code = code;
    exc_valid  = (kind == EXC) || (kind == ALL);
    irq_valid  = (kind == IRQ) || (kind == ALL);
    mret_valid = (kind == MRET) || (kind == ALL);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      busy_m[k] = busy; redir_m[k] = redirect_valid;
      taken_m[k] = irq_taken; rej_m[k] = irq_rejected;
      if (redirect_valid) rpc = redirect_pc;
      @(posedge clock); #1;
      if (k == 0) begin
        exc_valid = 1'b0; irq_valid = noise; mret_valid = noise;
      end
      if (k == 5) begin
        irq_valid = 1'b0; mret_valid = 1'b0;
      end
    end
    nwr = wr_count - w0;
  endtask

  task automatic do_trial(input string name, input int kind,
                          input logic [31:0] ms, tvec, mie, epc, cause, tval_old,
                          input logic [4:0] code, input logic [31:0] pc, tval, input bit noise,
                          output logic [31:0] obs_rpc);
    int n_cyc, n_wr, nwr;
    bit redir, taken, rej;
    logic [31:0] e_ms, e_epc, e_cause, e_tval, e_tgt, d;
    logic [15:0] busy_m, redir_m, taken_m, rej_m, eb, er;
    logic b;
    preset(ms, tvec, mie, epc, cause, tval_old);
    model(kind, ms, tvec, mie, epc, cause, tval_old, code, pc, tval,
          n_cyc, redir, taken, rej, n_wr, e_ms, e_epc, e_cause, e_tval, e_tgt);
    run_req(kind, code, pc, tval, noise, busy_m, redir_m, taken_m, rej_m, obs_rpc, nwr);
    eb = 16'((1 << (n_cyc + 1)) - 2);
    er = redir ? (16'd1 << n_cyc) : 16'd0;
    $display("trial %s kind=%0d code=%0d pc=%h tvec=%h rpc=%h", name, kind, code, pc, tvec, obs_rpc);
    total_cnt++;
    if (busy_m !== eb) $display("FAIL %s busy_mask: got %h expected %h", name, busy_m, eb);
    else pass_cnt++;
    total_cnt++;
    if (redir_m !== er) $display("FAIL %s redirect_mask: got %h expected %h", name, redir_m, er);
    else pass_cnt++;
    total_cnt++;
    if (taken_m !== (taken ? er : 16'd0))
      $display("FAIL %s irq_taken_mask: got %h expected %h", name, taken_m, taken ? er : 16'd0);
    else pass_cnt++;
    total_cnt++;
    if (rej_m !== (rej ? 16'h4 : 16'h0))
      $display("FAIL %s irq_rejected_mask: got %h expected %h", name, rej_m, rej ? 16'h4 : 16'h0);
    else pass_cnt++;
    if (redir) begin
      total_cnt++;
      if (obs_rpc !== e_tgt) $display("FAIL %s redirect_pc: got %h expected %h", name, obs_rpc, e_tgt);
      else pass_cnt++;
    end
    total_cnt++;
    if (nwr != n_wr) $display("FAIL %s write_count: got %0d expected %0d", name, nwr, n_wr);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (redirect_pc !== e_tgt) $display("FAIL %s redirect_hold: got %h expected %h", name, redirect_pc, e_tgt);
    else pass_cnt++;
    last_rpc = e_tgt;
    core_read(12'h300, d, b);
    total_cnt++;
    if (d !== e_ms) $display("FAIL %s mstatus: got %h expected %h", name, d, e_ms);
    else pass_cnt++;
    core_read(12'h341, d, b);
    total_cnt++;
    if (d !== e_epc) $display("FAIL %s mepc: got %h expected %h", name, d, e_epc);
    else pass_cnt++;
    core_read(12'h342, d, b);
    total_cnt++;
    if (d !== e_cause) $display("FAIL %s mcause: got %h expected %h", name, d, e_cause);
    else pass_cnt++;
    core_read(12'h343, d, b);
    total_cnt++;
    if (d !== e_tval) $display("FAIL %s mtval: got %h expected %h", name, d, e_tval);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total_cnt++;
    if ({busy, redirect_valid, irq_taken, irq_rejected} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {busy, redirect_valid, irq_taken, irq_rejected});
    else pass_cnt++;
    total_cnt++;
    if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc);
    else pass_cnt++;
    total_cnt++;
    if (wr_count != 0) $display("FAIL reset_writes: got %0d expected 0", wr_count);
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_passthrough();
    logic [31:0] d;
    logic b;
    core_write(12'h340, 32'hDEAD_BEEF);
    core_read(12'h340, d, b);
    $display("passthrough read 0x340 -> %h busy=%b", d, b);
    total_cnt++;
    if (d !== 32'hDEAD_BEEF) $display("FAIL passthrough_rd: got %h expected deadbeef", d);
    else pass_cnt++;
    total_cnt++;
    if (b !== 1'b0) $display("FAIL passthrough_busy: got %b expected 0", b);
    else pass_cnt++;
  endtask

  task automatic test_exception();
    logic [31:0] r;
    do_trial("exception", EXC, 32'h8, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0,
             5'd2, 32'h404, 32'h13, 1'b0, r);
    total_cnt++;
    if (r !== 32'h100) $display("FAIL exception_target: got %h expected 00000100", r);
    else pass_cnt++;
  endtask

  task automatic test_irq();
    logic [31:0] r;
    do_trial("irq_vectored", IRQ, 32'h8, 32'h101, 32'h80, 32'h0, 32'h0, 32'h55,
             5'd7, 32'h200, 32'h0, 1'b0, r);
    total_cnt++;
    if (r !== 32'h11C) $display("FAIL irq_target: got %h expected 0000011c", r);
    else pass_cnt++;
  endtask

  task automatic test_irq_reject();
    logic [31:0] r;
    do_trial("irq_reject", IRQ, 32'h8, 32'h101, 32'h0, 32'h0, 32'h0, 32'h0,
             5'd7, 32'h200, 32'h0, 1'b0, r);
    total_cnt++;
    if (redirect_pc !== 32'h11C) $display("FAIL irq_reject_hold: got %h expected 0000011c", redirect_pc);
    else pass_cnt++;
  endtask

  task automatic test_mret();
    logic [31:0] r;
    do_trial("mret", MRET, 32'h1880, 32'h100, 32'h0, 32'h404, 32'h2, 32'h13,
             5'd0, 32'h0, 32'h0, 1'b0, r);
    total_cnt++;
    if (r !== 32'h404) $display("FAIL mret_target: got %h expected 00000404", r);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [31:0] r;
    do_trial("priority", ALL, 32'h8, 32'h100, 32'hFFFF_FFFF, 32'h888, 32'h0, 32'h0,
             5'd3, 32'h40C, 32'h99, 1'b0, r);
    total_cnt++;
    if (r !== 32'h100) $display("FAIL priority_target: got %h expected 00000100", r);
    else pass_cnt++;
  endtask

  task automatic test_ignore_busy();
    logic [31:0] r;
    do_trial("ignore_busy", EXC, 32'h8, 32'h240, 32'hFFFF_FFFF, 32'h888, 32'h0, 32'h0,
             5'd11, 32'h600, 32'h1, 1'b1, r);
  endtask

  task automatic test_reset_abort();
    int w0, nred;
    logic [31:0] d;
    logic b;
    preset(32'h8, 32'h100, 32'h0, 32'h1111_1111, 32'h5A5A_5A5A, 32'h77);
    @(posedge clock); #1;
    w0 = wr_count;
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h404; exc_tval = 32'h13;
    @(posedge clock); #1;
    exc_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    total_cnt++;
    if (csr_bus.wen !== 1'b0) $display("FAIL abort_wen: got %b expected 0", csr_bus.wen);
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (redirect_pc !== 32'h0) $display("FAIL abort_redirect_pc: got %h expected 0", redirect_pc);
    else pass_cnt++;
    nred = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (redirect_valid === 1'b1) nred++;
    end
    total_cnt++;
    if (nred != 0) $display("FAIL abort_redirects: got %0d expected 0", nred);
    else pass_cnt++;
    total_cnt++;
    if (wr_count - w0 != 1) $display("FAIL abort_writes: got %0d expected 1", wr_count - w0);
    else pass_cnt++;
    core_read(12'h342, d, b);
    total_cnt++;
    if (d !== 32'h5A5A_5A5A) $display("FAIL abort_mcause: got %h expected 5a5a5a5a", d);
    else pass_cnt++;
    core_read(12'h341, d, b);
    total_cnt++;
    if (d !== 32'h404) $display("FAIL abort_mepc: got %h expected 00000404", d);
    else pass_cnt++;
    last_rpc = 32'h0;
    $display("reset abort done mepc=%h", d);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ms, tvec, pc, r1, r2, d;
    logic [15:0] busy_m, redir_m;
    logic b;
    ms = $urandom; tvec = $urandom & ~32'h3; pc = $urandom;
    preset(ms, tvec, 32'h0, 32'h0, 32'h0, 32'h0);
    busy_m = '0; redir_m = '0; r1 = '0; r2 = '0;
    @(posedge clock); #1;
    exc_valid = 1'b1; exc_code = 5'($urandom_range(0, 31)); exc_pc = pc; exc_tval = $urandom;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      busy_m[k] = busy; redir_m[k] = redirect_valid;
      if (k == 7) r1 = redirect_pc;
      if (k == 12) r2 = redirect_pc;
      @(posedge clock); #1;
      if (k == 0) exc_valid = 1'b0;
      if (k == 7) mret_valid = 1'b1;
      if (k == 8) mret_valid = 1'b0;
    end
    $display("back_to_back pc=%h trap_rpc=%h mret_rpc=%h", pc, r1, r2);
    total_cnt++;
    if (busy_m !== 16'h1EFE) $display("FAIL b2b_busy_mask: got %h expected 1efe", busy_m);
    else pass_cnt++;
    total_cnt++;
    if (redir_m !== 16'h1080) $display("FAIL b2b_redirect_mask: got %h expected 1080", redir_m);
    else pass_cnt++;
    total_cnt++;
    if (r1 !== tvec) $display("FAIL b2b_trap_target: got %h expected %h", r1, tvec);
    else pass_cnt++;
    total_cnt++;
    if (r2 !== (pc & ~32'h3)) $display("FAIL b2b_mret_target: got %h expected %h", r2, pc & ~32'h3);
    else pass_cnt++;
    core_read(12'h300, d, b);
    total_cnt++;
    if (d !== mret_st(trap_st(ms)))
      $display("FAIL b2b_mstatus: got %h expected %h", d, mret_st(trap_st(ms)));
    else pass_cnt++;
    last_rpc = pc & ~32'h3;
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] ms, tvec, mie, r;
    logic [4:0] code;
    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 2);
      ms = $urandom; tvec = $urandom; mie = $urandom;
      code = 5'($urandom_range(0, 31));
      if (kind == IRQ) begin
        case ($urandom_range(0, 2))
          0:       code = 5'd3;
          1:       code = 5'd7;
          default: code = 5'd11;
        endcase
        if ($urandom_range(0, 1) == 1) begin
          ms[3] = 1'b1; mie[code] = 1'b1;
        end
      end
      do_trial("random", kind, ms, tvec, mie, $urandom, $urandom, $urandom,
               code, $urandom, $urandom, 1'b0, r);
    end
  endtask

  initial begin
    core_bus.addr = '0; core_bus.ren = 1'b0; core_bus.wen = 1'b0; core_bus.wd = '0;
    test_reset();
    test_passthrough();
    test_exception();
    test_irq();
    test_irq_reject();
    test_mret();
    test_priority();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
